csr_unit: RTL

Machine-mode CSR unit for the RV32 core: the parametrised successor of the fixed-function CSR register file. It adds full CSRRW/CSRRS/CSRRC semantics, synchronous exceptions alongside interrupts, MRET, a prioritised multi-source interrupt controller with optional local lines, vectored trap dispatch and 64-bit cycle/instret counters. It sits beside the decode/execute stage, supplies trap and return targets to the fetch unit, and reads `pc` from the execute stage.

---
 rtl/csr_pkg.sv | 64 ++++++
 rtl/csr_unit_if.sv | 38 +++
 rtl/csr_counter64.sv | 29 ++
 rtl/csr_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit.
// Holds the CSR address map, the csr_op encoding, interrupt/exception cause
// codes, mstatus bit positions and the read-modify-write helper.
package csr_pkg;

    // CSR address map
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    // Interrupt cause codes (mcause[31] = 1)
    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    // Synchronous exception cause codes (mcause[31] = 0)
    localparam logic [3:0] EXC_IADDR_MISALIGNED = 4'd0;
    localparam logic [3:0] EXC_IACCESS_FAULT    = 4'd1;
    localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
    localparam logic [3:0] EXC_LADDR_MISALIGNED = 4'd4;
    localparam logic [3:0] EXC_LACCESS_FAULT    = 4'd5;
    localparam logic [3:0] EXC_SADDR_MISALIGNED = 4'd6;
    localparam logic [3:0] EXC_SACCESS_FAULT    = 4'd7;
    localparam logic [3:0] EXC_ECALL_M          = 4'd11;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // RV32I, machine mode only
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // New CSR value produced by a CSRRW/CSRRS/CSRRC style access
    function automatic logic [31:0] csr_apply_op(input logic [1:0] op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] d);
        case (op)
            OP_WRITE: csr_apply_op = d;
            OP_SET:   csr_apply_op = old_val | d;
            OP_CLEAR: csr_apply_op = old_val & ~d;
            default:  csr_apply_op = old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_unit_if.sv
// Bus between the core (decode/execute + fetch) and the CSR unit.
// master: core side, drives CSR access, pc, exception/MRET/retire and IRQ lines.
// slave:  CSR unit, returns read data, illegal flag and trap/MRET redirects.
interface csr_unit_if #(
    parameter int LIRQ_W = 1
);
    logic [11:0]       csr_addr;
    logic [1:0]        csr_op;
    logic [31:0]       csr_w_data;
    logic [31:0]       csr_r_data;
    logic              csr_illegal;
    logic [31:0]       pc;
    logic              exc_req;
    logic [3:0]        exc_cause;
    logic [31:0]       exc_tval;
    logic              mret_req;
    logic              instr_retire;
    logic              ext_irq;
    logic              timer_irq;
    logic              sw_irq;
    logic [LIRQ_W-1:0] local_irq;
    logic              trap_taken;
    logic [31:0]       trap_pc;
    logic              mret_taken;
    logic [31:0]       mret_pc;

    modport master (
        output csr_addr, csr_op, csr_w_data, pc, exc_req, exc_cause, exc_tval,
               mret_req, instr_retire, ext_irq, timer_irq, sw_irq, local_irq,
        input  csr_r_data, csr_illegal, trap_taken, trap_pc, mret_taken, mret_pc
    );

    modport slave (
        input  csr_addr, csr_op, csr_w_data, pc, exc_req, exc_cause, exc_tval,
               mret_req, instr_retire, ext_irq, timer_irq, sw_irq, local_irq,
        output csr_r_data, csr_illegal, trap_taken, trap_pc, mret_taken, mret_pc
    );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and a write port per
// 32-bit half. A write to either half takes precedence over the increment.
// Ports: clock, reset_n (async active-low), i_inc, i_wr_lo, i_wr_hi,
//        i_wdata (value for the selected half), o_value (current count).
module csr_counter64 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_value
);
    logic [63:0] r_value;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (i_wr_lo) begin
            r_value <= {r_value[63:32], i_wdata};
        end else if (i_wr_hi) begin
            r_value <= {i_wdata, r_value[31:0]};
        end else if (i_inc) begin
            r_value <= r_value + 64'd1;
        end
    end

    assign o_value = r_value;
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSR read/modify/write, synchronous exceptions,
// prioritised interrupts, MRET, vectored trap dispatch and 64-bit counters.
// Ports: clock, reset_n (async active-low), bus (csr_unit_if.slave) carrying
//        the CSR access, pc, exception/MRET/retire requests, IRQ lines and the
//        combinational read data, illegal flag and trap/MRET redirects.
module csr_unit
    import csr_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 0,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0500,
    parameter bit          IRQ_EN_RESET  = 1'b1,
    parameter int          HAS_COUNTERS  = 1
) (
    input  logic  clock,
    input  logic  reset_n,
    csr_unit_if.slave bus
);
    // Writable mie bits: MSI, MTI, MEI and the implemented local lines
    localparam logic [31:0] MIE_MASK =
        32'h0000_0888 | (((32'd1 << NUM_LOCAL_IRQ) - 32'd1) << 16);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [31:0] w_pend;
    logic [4:0]  w_irq_cause;
    logic        w_irq_take;
    logic [31:0] w_rdata;
    logic        w_impl;
    logic        w_ro;
    logic        w_illegal;
    logic [31:0] w_wval;
    logic        w_csr_we;
    logic [31:0] w_base;
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;

    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

    always_comb begin
        w_mip     = '0;
        w_mip[3]  = bus.sw_irq;
        w_mip[7]  = bus.timer_irq;
        w_mip[11] = bus.ext_irq;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            w_mip[16+i] = bus.local_irq[i];
        end
    end

    assign w_pend = w_mip & r_mie;

    // Later assignments override earlier ones: ascending locals so the highest
    // index wins, then MTI < MSI < MEI.
    always_comb begin
        w_irq_cause = '0;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            if (w_pend[16+i]) w_irq_cause = 5'(16 + i);
        end
        if (w_pend[7])  w_irq_cause = CAUSE_MTI;
        if (w_pend[3])  w_irq_cause = CAUSE_MSI;
        if (w_pend[11]) w_irq_cause = CAUSE_MEI;
    end

    assign w_irq_take = r_mstatus_mie && (w_pend != '0);

    always_comb begin
        w_rdata = '0;
        w_impl  = 1'b1;
        w_ro    = 1'b0;
        case (bus.csr_addr)
            CSR_MSTATUS:   w_rdata = w_mstatus;
            CSR_MISA:      begin w_rdata = MISA_VALUE; w_ro = 1'b1; end
            CSR_MHARTID:   w_ro = 1'b1;
            CSR_MIE:       w_rdata = r_mie;
            CSR_MTVEC:     w_rdata = r_mtvec;
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = r_mepc;
            CSR_MCAUSE:    w_rdata = r_mcause;
            CSR_MTVAL:     w_rdata = r_mtval;
            CSR_MIP:       begin w_rdata = w_mip; w_ro = 1'b1; end
            CSR_MCYCLE:    begin w_rdata = w_mcycle[31:0];    w_impl = (HAS_COUNTERS != 0); end
            CSR_MCYCLEH:   begin w_rdata = w_mcycle[63:32];   w_impl = (HAS_COUNTERS != 0); end
            CSR_MINSTRET:  begin w_rdata = w_minstret[31:0];  w_impl = (HAS_COUNTERS != 0); end
            CSR_MINSTRETH: begin w_rdata = w_minstret[63:32]; w_impl = (HAS_COUNTERS != 0); end
            default:       w_impl = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read, legal even on RO CSRs
    assign w_illegal = (bus.csr_op != OP_NONE) &&
                       (!w_impl || (w_ro && (bus.csr_op == OP_WRITE || bus.csr_w_data != '0)));

    assign w_wval   = csr_apply_op(bus.csr_op, w_rdata, bus.csr_w_data);
    assign w_csr_we = (bus.csr_op != OP_NONE) && !w_illegal && !bus.exc_req &&
                      !w_irq_take && !bus.mret_req;

    assign w_base          = {r_mtvec[31:2], 2'b00};
    assign bus.trap_taken  = bus.exc_req || w_irq_take;
    assign bus.trap_pc     = (r_mtvec[0] && !bus.exc_req && w_irq_take)
                             ? w_base + {25'b0, w_irq_cause, 2'b00} : w_base;
    assign bus.mret_taken  = bus.mret_req && !bus.trap_taken;
    assign bus.mret_pc     = r_mepc;
    assign bus.csr_r_data  = w_rdata;
    assign bus.csr_illegal = w_illegal;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mstatus_mie  <= IRQ_EN_RESET;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= IRQ_EN_RESET ? 32'h0000_0800 : 32'h0;
            r_mtvec        <= MTVEC_RESET & ~32'h2;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else if (bus.exc_req || w_irq_take) begin
            r_mepc         <= bus.pc & ~32'h3;
            r_mcause       <= bus.exc_req ? {28'b0, bus.exc_cause} : {1'b1, 26'b0, w_irq_cause};
            r_mtval        <= bus.exc_req ? bus.exc_tval : 32'h0;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (bus.mret_req) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_csr_we) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    r_mstatus_mie  <= w_wval[MSTATUS_MIE];
                    r_mstatus_mpie <= w_wval[MSTATUS_MPIE];
                end
                CSR_MIE:      r_mie      <= w_wval & MIE_MASK;
                CSR_MTVEC:    r_mtvec    <= w_wval & ~32'h2;
                CSR_MSCRATCH: r_mscratch <= w_wval;
                CSR_MEPC:     r_mepc     <= w_wval & ~32'h3;
                CSR_MCAUSE:   r_mcause   <= w_wval;
                CSR_MTVAL:    r_mtval    <= w_wval;
                default: ;
            endcase
        end
    end

    if (HAS_COUNTERS != 0) begin : g_counters
        csr_counter64 u_mcycle (
            .clock   (clock),
            .reset_n (reset_n),
            .i_inc   (1'b1),
            .i_wr_lo (w_csr_we && bus.csr_addr == CSR_MCYCLE),
            .i_wr_hi (w_csr_we && bus.csr_addr == CSR_MCYCLEH),
            .i_wdata (w_wval),
            .o_value (w_mcycle)
        );
        csr_counter64 u_minstret (
            .clock   (clock),
            .reset_n (reset_n),
            .i_inc   (bus.instr_retire),
            .i_wr_lo (w_csr_we && bus.csr_addr == CSR_MINSTRET),
            .i_wr_hi (w_csr_we && bus.csr_addr == CSR_MINSTRETH),
            .i_wdata (w_wval),
            .o_value (w_minstret)
        );
    end else begin : g_no_counters
        assign w_mcycle   = '0;
        assign w_minstret = '0;
    end
endmodule
